cpu_seq: RTL and testbench

Multi-cycle instruction sequencer for the CPU core. It fetches an instruction over a request/acknowledge instruction-memory port and holds it in an instruction register that drives the decoder's `MEM_INST`. It then steps the decoder, data memory, register file and PC through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, and emits the per-instruction strobes (`INST_ENB`, `RF_WE`, `PC_CLK`). It also detects illegal opcodes and memory timeouts.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cpu_seq_if.sv | 36 +++
 rtl/seq_timer.sv | 36 +++
 rtl/cpu_seq.sv | 114 +++++++++++
 tb/tb_cpu_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU core sequencer.
//   state_t   - sequencer state encoding (exported on STATE)
//   cause_t   - fault-cause codes (exported on FAULT_CAUSE)
//   OP_*      - RV32 major opcode constants (INST[6:0])
//   is_legal_op - opcode legality check used in DECODE
package cpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6,
      S_FAULT     = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_FETCH_TO = 2'd1,
      CAUSE_ILLEGAL  = 2'd2,
      CAUSE_DATA_TO  = 2'd3
   } cause_t;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_FENCE  = 7'h0F;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   // ADDI x0,x0,0 - value held in the instruction register out of reset
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   function automatic logic is_legal_op(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
         OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_seq_if.sv
// cpu_seq_if: sequencer-facing bus bundle (run control, instruction memory,
// decoder, data memory, register-file/PC strobes and status).
//   master - the sequencer (drives requests, strobes, INST and status)
//   slave  - memories / decoder / environment
interface cpu_seq_if #(
   parameter int XLEN = 32
);
   logic            RUN;
   logic            IMEM_REQ;
   logic            IMEM_ACK;
   logic [XLEN-1:0] IMEM_DATA;
   logic [XLEN-1:0] INST;
   logic            INST_ENB;
   logic            CU_WRITE_ENB;
   logic            DMEM_REQ;
   logic            DMEM_WE;
   logic            DMEM_ACK;
   logic            RF_WE;
   logic            PC_CLK;
   logic [2:0]      STATE;
   logic            FAULT;
   logic [1:0]      FAULT_CAUSE;
   logic [31:0]     INSTRET;

   modport master (
      input  RUN, IMEM_ACK, IMEM_DATA, CU_WRITE_ENB, DMEM_ACK,
      output IMEM_REQ, INST, INST_ENB, DMEM_REQ, DMEM_WE, RF_WE, PC_CLK,
             STATE, FAULT, FAULT_CAUSE, INSTRET
   );

   modport slave (
      output RUN, IMEM_ACK, IMEM_DATA, CU_WRITE_ENB, DMEM_ACK,
      input  IMEM_REQ, INST, INST_ENB, DMEM_REQ, DMEM_WE, RF_WE, PC_CLK,
             STATE, FAULT, FAULT_CAUSE, INSTRET
   );
endinterface

// File: rtl/seq_timer.sv
// seq_timer: memory-request timeout counter, shared by FETCH and MEMORY.
//   CLK, RST_N - clock, async active-low reset
//   clr        - hold the count at zero (outside a request state)
//   cnt_en     - a request is outstanding this cycle
//   ack        - the request is acknowledged this cycle
//   expired    - this is the MEM_TIMEOUT-th un-acknowledged request cycle
// MEM_TIMEOUT = 0 disables expiry.
module seq_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   input  logic cnt_en,
   input  logic ack,
   output logic expired
);
   localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [W-1:0] LIMIT = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [W-1:0] cnt_q;

   // The count holds the number of earlier wait cycles, so the current cycle
   // is the last allowed one when it equals LIMIT; an ack here still wins.
   assign expired = (MEM_TIMEOUT != 0) && cnt_en && !ack && (cnt_q == LIMIT);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (cnt_en && !ack && !expired) begin
         cnt_q <= cnt_q + W'(1);
      end
   end
endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer.
//   CLK   - system clock, rising edge
//   RST_N - asynchronous active-low reset
//   bus   - cpu_seq_if master: RUN, instruction fetch (IMEM_*), decoder
//           (INST, INST_ENB, CU_WRITE_ENB), data memory (DMEM_*), RF_WE,
//           PC_CLK, STATE, FAULT, FAULT_CAUSE, INSTRET
// Steps FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK; HALT and FAULT are terminal.
module cpu_seq
   import cpu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input logic        CLK,
   input logic        RST_N,
   cpu_seq_if.master  bus
);
   state_t          state_q, state_d;
   cause_t          cause_q, cause_d;
   logic [XLEN-1:0] inst_q;
   logic [31:0]     instret_q;
   logic [6:0]      opcode;
   logic            tmr_clr, tmr_en, tmr_ack, tmr_expired;

   assign opcode = inst_q[6:0];

   // FETCH and MEMORY are never back-to-back, so holding the count clear in
   // every other state is the same as clearing it on entry.
   assign tmr_en  = (state_q == S_FETCH) || (state_q == S_MEMORY);
   assign tmr_clr = !tmr_en;
   assign tmr_ack = (state_q == S_FETCH) ? bus.IMEM_ACK : bus.DMEM_ACK;

   seq_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clr     (tmr_clr),
      .cnt_en  (tmr_en),
      .ack     (tmr_ack),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: if (bus.RUN) state_d = S_FETCH;
         S_FETCH: begin
            if (bus.IMEM_ACK) begin
               state_d = S_DECODE;
            end else if (tmr_expired) begin
               state_d = S_FAULT;
               cause_d = CAUSE_FETCH_TO;
            end
         end
         S_DECODE: begin
            if (is_legal_op(opcode)) begin
               state_d = S_EXECUTE;
            end else begin
               state_d = S_FAULT;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXECUTE: begin
            if (opcode == OP_LOAD || opcode == OP_STORE)
               state_d = S_MEMORY;
            else if (opcode == OP_SYSTEM && inst_q[14:12] == 3'd0)
               state_d = S_HALT;
            else
               state_d = S_WRITEBACK;
         end
         S_MEMORY: begin
            if (bus.DMEM_ACK) begin
               state_d = S_WRITEBACK;
            end else if (tmr_expired) begin
               state_d = S_FAULT;
               cause_d = CAUSE_DATA_TO;
            end
         end
         S_WRITEBACK: state_d = bus.RUN ? S_FETCH : S_IDLE;
         S_HALT:      state_d = S_HALT;
         S_FAULT:     state_d = S_FAULT;
         default:     state_d = S_FAULT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         cause_q   <= CAUSE_NONE;
         inst_q    <= XLEN'(INST_NOP);
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_q == S_FETCH && bus.IMEM_ACK)
            inst_q <= bus.IMEM_DATA;
         if (state_q == S_WRITEBACK)
            instret_q <= instret_q + 32'd1;
      end
   end

   assign bus.IMEM_REQ    = (state_q == S_FETCH);
   assign bus.INST        = inst_q;
   assign bus.INST_ENB    = (state_q == S_DECODE);
   assign bus.DMEM_REQ    = (state_q == S_MEMORY);
   assign bus.DMEM_WE     = (state_q == S_MEMORY) && (opcode == OP_STORE);
   assign bus.RF_WE       = (state_q == S_WRITEBACK) && bus.CU_WRITE_ENB &&
                            (inst_q[11:7] != 5'd0) && (opcode != OP_STORE);
   assign bus.PC_CLK      = (state_q == S_WRITEBACK);
   assign bus.STATE       = state_q;
   assign bus.FAULT       = (state_q == S_FAULT);
   assign bus.FAULT_CAUSE = cause_q;
   assign bus.INSTRET     = instret_q;
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed self-checking bench for cpu_seq.
module tb_cpu_seq;
   logic CLK;
   logic RST_N;
   int   checks;
   int   errors;

   localparam logic [31:0] I_ADD  = 32'h0030_8133;
   localparam logic [31:0] I_LW   = 32'h0000_A103;
   localparam logic [31:0] I_SW   = 32'h0020_A023;
   localparam logic [31:0] I_ADDI = 32'h0010_0013;
   localparam logic [31:0] I_ILL  = 32'h0000_007F;
   localparam logic [31:0] I_ECAL = 32'h0000_0073;

   cpu_seq_if #(.XLEN(32)) bus ();

   cpu_seq #(.XLEN(32), .MEM_TIMEOUT(15)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one cycle; sample 1 time unit after the rising edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset();
      RST_N = 1'b0;
      #1;
      chk("rst_state", 32'(bus.STATE), 32'd0);
      RST_N = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST_N            = 1'b0;
      bus.RUN          = 1'b0;
      bus.IMEM_ACK     = 1'b0;
      bus.IMEM_DATA    = '0;
      bus.CU_WRITE_ENB = 1'b1;
      bus.DMEM_ACK     = 1'b0;
      #12;
      chk("reset_state",   32'(bus.STATE), 32'd0);
      chk("reset_inst",    bus.INST, 32'h13);
      chk("reset_instret", bus.INSTRET, 32'd0);
      chk("reset_fault",   32'(bus.FAULT), 32'd0);
      chk("reset_cause",   32'(bus.FAULT_CAUSE), 32'd0);
      chk("reset_strobes", 32'({bus.IMEM_REQ, bus.INST_ENB, bus.DMEM_REQ, bus.DMEM_WE,
                                bus.RF_WE, bus.PC_CLK}), 32'd0);

      // ADD, zero-wait
      RST_N = 1'b1; bus.RUN = 1'b1; bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = I_ADD;
      bus.DMEM_ACK = 1'b1;
      step(); chk("add_fetch", 32'(bus.STATE), 32'd1);
      chk("add_imem_req", 32'(bus.IMEM_REQ), 32'd1);
      step(); chk("add_decode", 32'(bus.STATE), 32'd2);
      chk("add_inst", bus.INST, I_ADD);
      chk("add_inst_enb", 32'(bus.INST_ENB), 32'd1);
      step(); chk("add_execute", 32'(bus.STATE), 32'd3);
      chk("add_inst_enb_off", 32'(bus.INST_ENB), 32'd0);
      step(); chk("add_wb", 32'(bus.STATE), 32'd5);
      chk("add_rf_pc", 32'({bus.RF_WE, bus.PC_CLK}), 32'd3);
      chk("add_instret_wb", bus.INSTRET, 32'd0);

      // LW with DMEM_ACK arriving in the 4th MEMORY cycle
      bus.IMEM_DATA = I_LW; bus.DMEM_ACK = 1'b0;
      step(); chk("lw_fetch", 32'(bus.STATE), 32'd1);
      chk("add_instret", bus.INSTRET, 32'd1);
      chk("lw_rf_off", 32'(bus.RF_WE), 32'd0);
      step(); chk("lw_inst", bus.INST, I_LW);
      step(); chk("lw_execute", 32'(bus.STATE), 32'd3);
      step(); chk("lw_mem1", 32'(bus.STATE), 32'd4);
      chk("lw_req_we", 32'({bus.DMEM_REQ, bus.DMEM_WE}), 32'd2);
      step(); chk("lw_mem2", 32'(bus.STATE), 32'd4);
      step(); chk("lw_mem3", 32'(bus.STATE), 32'd4);
      step(); chk("lw_mem4", 32'(bus.STATE), 32'd4);
      bus.DMEM_ACK = 1'b1; bus.IMEM_DATA = I_SW;
      step(); chk("lw_wb", 32'(bus.STATE), 32'd5);
      chk("lw_rf_pc", 32'({bus.RF_WE, bus.PC_CLK}), 32'd3);

      // SW, zero-wait
      step(); chk("sw_fetch", 32'(bus.STATE), 32'd1);
      chk("lw_instret", bus.INSTRET, 32'd2);
      step(); step();
      step(); chk("sw_mem", 32'(bus.STATE), 32'd4);
      chk("sw_req_we", 32'({bus.DMEM_REQ, bus.DMEM_WE}), 32'd3);
      step(); chk("sw_wb", 32'(bus.STATE), 32'd5);
      chk("sw_rf_pc", 32'({bus.RF_WE, bus.PC_CLK}), 32'd1);

      // ADDI x0 with RUN dropped in EXECUTE
      bus.IMEM_DATA = I_ADDI;
      step(); chk("sw_instret", bus.INSTRET, 32'd3);
      step();
      step(); chk("addi_execute", 32'(bus.STATE), 32'd3);
      bus.RUN = 1'b0;
      step(); chk("addi_wb", 32'(bus.STATE), 32'd5);
      chk("addi_rf_pc", 32'({bus.RF_WE, bus.PC_CLK}), 32'd1);
      step(); chk("addi_idle", 32'(bus.STATE), 32'd0);
      chk("addi_instret", bus.INSTRET, 32'd4);
      step(); chk("idle_stays", 32'(bus.STATE), 32'd0);
      chk("idle_no_req", 32'(bus.IMEM_REQ), 32'd0);

      // reset pulsed in MEMORY
      bus.RUN = 1'b1; bus.IMEM_DATA = I_LW; bus.DMEM_ACK = 1'b0;
      step(); step(); step();
      step(); chk("rstmem_mem", 32'(bus.STATE), 32'd4);
      #2;
      RST_N = 1'b0;
      #1;
      chk("rstmem_state", 32'(bus.STATE), 32'd0);
      chk("rstmem_strobes", 32'({bus.DMEM_REQ, bus.RF_WE, bus.PC_CLK}), 32'd0);
      chk("rstmem_instret", bus.INSTRET, 32'd0);
      chk("rstmem_inst", bus.INST, 32'h13);
      step(); chk("rstmem_held", 32'(bus.STATE), 32'd0);

      // fetch timeout: 15 FETCH cycles then FAULT
      bus.IMEM_ACK = 1'b0;
      RST_N = 1'b1;
      step(); chk("fto_fetch1", 32'(bus.STATE), 32'd1);
      repeat (14) step();
      chk("fto_fetch15", 32'(bus.STATE), 32'd1);
      step(); chk("fto_fault", 32'(bus.STATE), 32'd7);
      chk("fto_flag", 32'(bus.FAULT), 32'd1);
      chk("fto_cause", 32'(bus.FAULT_CAUSE), 32'd1);
      chk("fto_req_off", 32'(bus.IMEM_REQ), 32'd0);
      step(); chk("fto_sticky", 32'({bus.STATE, bus.FAULT_CAUSE}), 32'h1D);

      // ack on the 15th FETCH cycle wins, then illegal opcode
      pulse_reset();
      chk("rst_clears_fault", 32'({bus.FAULT, bus.FAULT_CAUSE}), 32'd0);
      step(); chk("ack15_fetch1", 32'(bus.STATE), 32'd1);
      repeat (14) step();
      chk("ack15_fetch15", 32'(bus.STATE), 32'd1);
      bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = I_ILL;
      step(); chk("ack15_decode", 32'(bus.STATE), 32'd2);
      chk("ack15_nofault", 32'(bus.FAULT), 32'd0);
      chk("ill_pc_decode", 32'(bus.PC_CLK), 32'd0);
      step(); chk("ill_fault", 32'(bus.STATE), 32'd7);
      chk("ill_cause", 32'(bus.FAULT_CAUSE), 32'd2);
      chk("ill_pc_fault", 32'(bus.PC_CLK), 32'd0);
      step(); chk("ill_sticky", 32'(bus.STATE), 32'd7);

      // data timeout: 15 MEMORY cycles then FAULT
      bus.IMEM_DATA = I_LW; bus.DMEM_ACK = 1'b0;
      pulse_reset();
      step(); step(); step();
      step(); chk("dto_mem1", 32'(bus.STATE), 32'd4);
      repeat (14) step();
      chk("dto_mem15", 32'(bus.STATE), 32'd4);
      step(); chk("dto_fault", 32'(bus.STATE), 32'd7);
      chk("dto_cause", 32'(bus.FAULT_CAUSE), 32'd3);
      chk("dto_req_off", 32'(bus.DMEM_REQ), 32'd0);

      // ECALL halts without retiring
      bus.IMEM_DATA = I_ECAL;
      pulse_reset();
      step(); step();
      step(); chk("ecall_execute", 32'(bus.STATE), 32'd3);
      step(); chk("ecall_halt", 32'(bus.STATE), 32'd6);
      chk("ecall_instret", bus.INSTRET, 32'd0);
      chk("ecall_no_pc", 32'(bus.PC_CLK), 32'd0);
      step(); chk("ecall_sticky", 32'(bus.STATE), 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
